bin_morph_3x3: RTL and testbench
================================

BIN_MORPH_3X3 -- requirements
Module: bin_morph_3x3

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 1920, pixels per line (2..4095).
REQ-002 SHALL have parameter IMG_HEIGHT, default 1080, lines per frame (2..4095).
REQ-003 SHALL have parameter MODE, default 0, 0 = erosion (AND of 9), 1 = dilation (OR of 9).
REQ-004 SHALL have port clka  input  1  clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  input pixel qualifier.
REQ-007 SHALL have port in_sof  input  1  first pixel of frame; meaningful only with in_valid.
REQ-008 SHALL have port in_bit  input  1  binary input pixel.
REQ-009 SHALL have port out_valid  output  1  output pixel qualifier.
REQ-010 SHALL have port out_sof  output  1  marks output belonging to the in_sof pixel.
REQ-011 SHALL have port out_bit  output  1  morphology result.
REQ-012 SHALL have port out_eof  output  1  one-cycle pulse with the output of pixel (IMG_HEIGHT-1, IMG_WIDTH-1).

Function
REQ-013 SHALL keep column counter col (12 bit) and row counter row (12 bit), advanced only on cycles with in_valid=1.
REQ-014 SHALL treat an in_valid pixel with in_sof=1 as (0,0), regardless of counter state.
REQ-015 SHALL wrap col from IMG_WIDTH-1 to 0 and increment row; row SHALL saturate at IMG_HEIGHT-1 (extra lines processed as last row).
REQ-016 SHALL hold two internal 1-bit x IMG_WIDTH line stores: LB1 = row r-1, LB2 = row r-2, indexed by col, read-before-write.
REQ-017 SHALL, per accepted pixel (r,c), form a 3x3 window of rows r-2..r, cols c-2..c from in_bit, LB1[c], LB2[c] and two-deep column shift registers.
REQ-018 SHALL produce exactly one output per accepted input, out_valid asserted exactly 2 clka cycles after the accepting in_valid cycle.
REQ-019 SHALL define the output for input (r,c) as centre pixel (r-1,c-1): MODE 0 AND of window, MODE 1 OR of window.
REQ-020 SHALL force out_bit=0 when r<2 or c<2 (border, incl. any stale line-store content).
REQ-021 SHALL stall completely during in_valid=0 gaps: counters, shift registers and line stores unchanged; output stream independent of gap pattern.
REQ-022 SHALL assert out_sof and out_eof only together with out_valid, aligned to the same 2-cycle latency.
REQ-023 SHALL hold out_bit unchanged when out_valid=0.
REQ-024 SHALL handle in_sof mid-frame by restarting at (0,0) immediately; outputs already in flight SHALL still be emitted.

Reset
REQ-025 SHALL, on rst_n=0, asynchronously clear out_valid, out_sof, out_bit, out_eof, col, row, window registers and pipeline stage to 0.
REQ-026 SHALL NOT require line-store clearing at reset; REQ-020 masks stale content.
REQ-027 SHALL accept input on the first clka edge after rst_n deasserts; in-flight outputs at reset SHALL be discarded.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6)
REQ-028 SHALL verify reset: rst_n=0 mid-frame -> all outputs 0 immediately; restart frame -> output identical to clean run.
REQ-029 SHALL verify MODE 0, all-ones frame, continuous valid -> 48 outputs, exactly 24 ones (r,c>=2), first out_valid 2 cycles after first in_valid.
REQ-030 SHALL verify MODE 1, single 1 at input (3,4), rest 0 -> exactly 9 ones, at outputs for inputs r=3..5, c=4..6.
REQ-031 SHALL verify MODE 0, all ones except 0 at (3,4) -> 15 ones; zeros at inputs r=3..5, c=4..6 plus border.
REQ-032 SHALL verify random in_valid throttling (~50%) over 3 frames -> out stream bit-identical to continuous run; one out_sof and one out_eof per frame.
REQ-033 SHALL verify in_sof asserted at input (2,5) -> counters restart; next two rows output 0 (border masking).

Source files
------------

// File: rtl/bin_morph_3x3.sv
// Binary 3x3 erosion/dilation over a raster pixel stream.
// Line stores hold the two previous rows; results come out two cycles after acceptance.
module bin_morph_3x3 #(
    parameter int IMG_WIDTH  = 1920,
    parameter int IMG_HEIGHT = 1080,
    parameter int MODE       = 0
) (
    input  logic clka,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_sof,
    input  logic in_bit,
    output logic out_valid,
    output logic out_sof,
    output logic out_bit,
    output logic out_eof
);

    localparam int          CW       = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [11:0] COL_LAST = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] ROW_LAST = 12'(IMG_HEIGHT - 1);

    logic [11:0]          col_q, col_d, row_q, row_d;
    logic [2:0]           sh1_q, sh1_d, sh2_q, sh2_d;
    logic [IMG_WIDTH-1:0] lb1_q, lb2_q;
    logic                 p1_valid_q, p1_bit_q, p1_sof_q, p1_eof_q;
    logic                 p1_valid_d, p1_bit_d, p1_sof_d, p1_eof_d;
    logic                 out_valid_q, out_sof_q, out_bit_q, out_eof_q;
    logic                 out_valid_d, out_sof_d, out_bit_d, out_eof_d;

    logic [11:0]   cur_col_s, cur_row_s;
    logic [CW-1:0] cidx_s;
    logic [2:0]    col_vec_s;
    logic [8:0]    win_s;
    logic          morph_s, border_s, last_pix_s;

    // Window formation, position tracking and pipeline next-state.
    always_comb begin
        cur_col_s  = in_sof ? 12'd0 : col_q;
        cur_row_s  = in_sof ? 12'd0 : row_q;
        cidx_s     = cur_col_s[CW-1:0];
        col_vec_s  = {lb2_q[cidx_s], lb1_q[cidx_s], in_bit};
        win_s      = {col_vec_s, sh1_q, sh2_q};
        morph_s    = (MODE == 1) ? (|win_s) : (&win_s);
        // Rows/cols below 2 see wrapped shift data or stale line stores.
        border_s   = (cur_row_s < 12'd2) || (cur_col_s < 12'd2);
        last_pix_s = (cur_row_s == ROW_LAST) && (cur_col_s == COL_LAST);

        col_d = col_q;
        row_d = row_q;
        sh1_d = sh1_q;
        sh2_d = sh2_q;
        if (in_valid) begin
            sh1_d = col_vec_s;
            sh2_d = sh1_q;
            if (cur_col_s == COL_LAST) begin
                col_d = 12'd0;
                row_d = (cur_row_s == ROW_LAST) ? cur_row_s : cur_row_s + 12'd1;
            end else begin
                col_d = cur_col_s + 12'd1;
                row_d = cur_row_s;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end

        p1_valid_d = in_valid;
        p1_bit_d   = morph_s & ~border_s;
        p1_sof_d   = in_valid & in_sof;
        p1_eof_d   = in_valid & last_pix_s;

        out_valid_d = p1_valid_q;
        out_sof_d   = p1_valid_q & p1_sof_q;
        out_eof_d   = p1_valid_q & p1_eof_q;
        if (p1_valid_q) begin
            out_bit_d = p1_bit_q;
        end else begin
            out_bit_d = out_bit_q;
        end
    end

    // Counters, column shift registers and the two-stage output pipeline.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= 12'd0;
            row_q       <= 12'd0;
            sh1_q       <= 3'd0;
            sh2_q       <= 3'd0;
            p1_valid_q  <= 1'b0;
            p1_bit_q    <= 1'b0;
            p1_sof_q    <= 1'b0;
            p1_eof_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_bit_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            sh1_q       <= sh1_d;
            sh2_q       <= sh2_d;
            p1_valid_q  <= p1_valid_d;
            p1_bit_q    <= p1_bit_d;
            p1_sof_q    <= p1_sof_d;
            p1_eof_q    <= p1_eof_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_bit_q   <= out_bit_d;
            out_eof_q   <= out_eof_d;
        end
    end

    // Line stores: read-before-write, not reset (border masking hides stale data).
    always_ff @(posedge clka) begin
        if (in_valid) begin
            lb1_q[cidx_s] <= in_bit;
            lb2_q[cidx_s] <= lb1_q[cidx_s];
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_bit   = out_bit_q;
    assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_bin_morph_3x3.sv
// Scoreboard bench for bin_morph_3x3: erosion and dilation instances share one stimulus stream.
`timescale 1ns/1ps
module tb_bin_morph_3x3;

    localparam int W = 8;
    localparam int H = 6;

    typedef struct packed {
        logic b;
        logic s;
        logic e;
        int   cyc;
    } exp_t;

    logic clka = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_sof = 1'b0;
    logic in_bit = 1'b0;
    logic o0_valid, o0_sof, o0_bit, o0_eof;
    logic o1_valid, o1_sof, o1_bit, o1_eof;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   ones0 = 0, ones1 = 0, sofs = 0, eofs = 0;
    logic lastb [2];
    exp_t q0 [$];
    exp_t q1 [$];
    logic img [0:H-1][0:W-1];
    int   mr = 0, mc = 0;

    bin_morph_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MODE(0)) u_ero (
        .clka(clka), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_bit(in_bit),
        .out_valid(o0_valid), .out_sof(o0_sof), .out_bit(o0_bit), .out_eof(o0_eof));

    bin_morph_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MODE(1)) u_dil (
        .clka(clka), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_bit(in_bit),
        .out_valid(o1_valid), .out_sof(o1_sof), .out_bit(o1_bit), .out_eof(o1_eof));

    always #5 clka = ~clka;

    always @(posedge clka) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    function automatic int pix(input int kind, input int r, input int c);
        case (kind)
            0:       pix = 1;
            1:       pix = (r == 3 && c == 4) ? 1 : 0;
            2:       pix = (r == 3 && c == 4) ? 0 : 1;
            3:       pix = ((r * 3 + c * 5) % 7 < 5) ? 1 : 0;
            default: pix = ((r + c) % 4 != 0) ? 1 : 0;
        endcase
    endfunction

    // Reference: direct 3x3 neighbourhood over the image as written so far.
    function automatic logic exp_bit(input int mode);
        logic acc;
        if (mr < 2 || mc < 2) return 1'b0;
        acc = (mode == 1) ? 1'b0 : 1'b1;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                if (mode == 1) acc = acc | img[mr-dr][mc-dc];
                else           acc = acc & img[mr-dr][mc-dc];
        return acc;
    endfunction

    task automatic mon(input int m, input logic ov, input logic ob, input logic os, input logic oe);
        exp_t x;
        int   qs;
        checks++;
        if (ov) begin
            qs = (m == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
                errors++;
                $display("FAIL unexpected_out m=%0d got out_valid=1 required no output", m);
            end else begin
                x = (m == 0) ? q0.pop_front() : q1.pop_front();
                if (ob !== x.b || os !== x.s || oe !== x.e || (cyc - x.cyc) != 2) begin
                    errors++;
                    $display("FAIL pix_out m=%0d got bit=%b sof=%b eof=%b lat=%0d required bit=%b sof=%b eof=%b lat=2",
                             m, ob, os, oe, cyc - x.cyc, x.b, x.s, x.e);
                end
            end
            if (m == 0) begin
                ones0 += int'(ob);
                sofs  += int'(os);
                eofs  += int'(oe);
            end else begin
                ones1 += int'(ob);
            end
            lastb[m] = ob;
        end else if (os !== 1'b0 || oe !== 1'b0 || ob !== lastb[m]) begin
            errors++;
            $display("FAIL idle_hold m=%0d got sof=%b eof=%b bit=%b required sof=0 eof=0 bit=%b",
                     m, os, oe, ob, lastb[m]);
        end
    endtask

    always @(negedge clka) begin
        if (rst_n === 1'b1) begin
            mon(0, o0_valid, o0_bit, o0_sof, o0_eof);
            mon(1, o1_valid, o1_bit, o1_sof, o1_eof);
        end
    end

    task automatic send(input logic b, input logic s, input bit thr);
        exp_t x;
        int   g;
        g = 0;
        if (thr) g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
        repeat (g) begin
            @(negedge clka);
            in_valid = 1'b0;
            in_bit   = 1'($urandom_range(0, 1));
            in_sof   = 1'($urandom_range(0, 1));
        end
        @(negedge clka);
        if (s) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = b;
        x.s   = s;
        x.e   = (mr == H - 1 && mc == W - 1);
        x.cyc = cyc;
        x.b   = exp_bit(0);
        q0.push_back(x);
        x.b   = exp_bit(1);
        q1.push_back(x);
        if (mc == W - 1) begin
            mc = 0;
            if (mr < H - 1) mr++;
        end else begin
            mc++;
        end
        in_valid = 1'b1;
        in_bit   = b;
        in_sof   = s;
    endtask

    task automatic drain(input string name);
        @(negedge clka);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (4) @(negedge clka);
        chk({name, "_q0_empty"}, q0.size(), 0);
        chk({name, "_q1_empty"}, q1.size(), 0);
    endtask

    task automatic clr_counts();
        ones0 = 0;
        ones1 = 0;
        sofs  = 0;
        eofs  = 0;
    endtask

    task automatic run_frame(input int kind, input bit thr);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(1'(pix(kind, r, c)), (r == 0 && c == 0), thr);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        lastb[0] = 1'b0;
        lastb[1] = 1'b0;
        repeat (3) @(negedge clka);
        chk("reset_outs_ero", int'({o0_valid, o0_sof, o0_bit, o0_eof}), 0);
        chk("reset_outs_dil", int'({o1_valid, o1_sof, o1_bit, o1_eof}), 0);
        rst_n = 1'b1;

        // All ones, continuous.
        clr_counts();
        run_frame(0, 1'b0);
        drain("allones");
        chk("allones_ero_ones", ones0, 24);
        chk("allones_dil_ones", ones1, 24);
        chk("allones_sof", sofs, 1);
        chk("allones_eof", eofs, 1);

        // Single one at (3,4).
        clr_counts();
        run_frame(1, 1'b0);
        drain("single");
        chk("single_dil_ones", ones1, 9);
        chk("single_ero_ones", ones0, 0);

        // All ones with a hole at (3,4).
        clr_counts();
        run_frame(2, 1'b0);
        drain("hole");
        chk("hole_ero_ones", ones0, 15);
        chk("hole_dil_ones", ones1, 24);

        // Three throttled frames.
        clr_counts();
        run_frame(3, 1'b1);
        run_frame(4, 1'b1);
        run_frame(0, 1'b1);
        drain("throttle");
        chk("throttle_sof", sofs, 3);
        chk("throttle_eof", eofs, 3);

        // Asynchronous reset mid-frame, then a clean restart.
        for (int i = 0; i < 20; i++) send(1'b1, (i == 0), 1'b0);
        @(negedge clka);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1;
        chk("midrst_outs_ero", int'({o0_valid, o0_sof, o0_bit, o0_eof}), 0);
        chk("midrst_outs_dil", int'({o1_valid, o1_sof, o1_bit, o1_eof}), 0);
        q0.delete();
        q1.delete();
        mr = 0;
        mc = 0;
        lastb[0] = 1'b0;
        lastb[1] = 1'b0;
        repeat (2) @(negedge clka);
        rst_n = 1'b1;
        clr_counts();
        run_frame(0, 1'b0);
        drain("afterrst");
        chk("afterrst_ero_ones", ones0, 24);
        chk("afterrst_sof", sofs, 1);

        // in_sof at input (2,5): in-flight outputs kept, counters restart.
        clr_counts();
        for (int i = 0; i < 21; i++) send(1'b1, (i == 0), 1'b0);
        run_frame(0, 1'b0);
        drain("midsof");
        chk("midsof_ero_ones", ones0, 27);
        chk("midsof_sof", sofs, 2);
        chk("midsof_eof", eofs, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
